// File: rtl/pcsfec_rx_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// pcsfec_rx_frame_buffer_if
// Bundles the two word streams around the receive frame buffer:
//   - PCS/FEC side : phy_llp_data, phy_llp_data_valid, phy_llp_data_error,
//                    phy_llp_ready (lanes locked and aligned)
//   - link side    : out_data, out_error, out_valid (head of FIFO) and
//                    in_ready (link layer accepts the head word)
// Modports:
//   slave  - the frame buffer: consumes the PCS/FEC stream and in_ready,
//            sources the out_* stream
//   master - the surrounding environment (PCS/FEC core plus link layer)
// Parameter DATA_W : word width, must match the frame buffer instance.
// ---------------------------------------------------------------------------
interface pcsfec_rx_frame_buffer_if #(
    parameter int DATA_W = 256
) ();

    logic [DATA_W-1:0] phy_llp_data;
    logic              phy_llp_data_valid;
    logic              phy_llp_data_error;
    logic              phy_llp_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_error;
    logic              out_valid;
    logic              in_ready;

    modport slave (
        input  phy_llp_data,
        input  phy_llp_data_valid,
        input  phy_llp_data_error,
        input  phy_llp_ready,
        input  in_ready,
        output out_data,
        output out_error,
        output out_valid
    );

    modport master (
        output phy_llp_data,
        output phy_llp_data_valid,
        output phy_llp_data_error,
        output phy_llp_ready,
        output in_ready,
        input  out_data,
        input  out_error,
        input  out_valid
    );

endinterface

// File: rtl/pcsfec_rx_frame_buffer.sv
// ---------------------------------------------------------------------------
// pcsfec_rx_frame_buffer
// Receive stage behind the PCS/FEC core. Words are accepted only while the
// debounced link state machine is UP, buffered in a first-word-fall-through
// FIFO and handed to the link layer with valid/ready back-pressure. Keeps a
// sticky overflow flag and a saturating errored-word counter for CSRs.
//
// Ports:
//   clkcore          core clock
//   reset_n_core     asynchronous active-low reset
//   in_enable        block enable from CSR
//   bus (slave)      PCS/FEC input stream and link-layer output stream
//   out_link_up      link state machine is UP
//   out_fill_level   FIFO occupancy (0..DEPTH)
//   out_overflow     sticky: a word was dropped because the FIFO was full
//   in_overflow_clr  clears out_overflow (a new drop in the same cycle wins)
//   out_err_count    saturating count of errored words seen while UP
//   in_err_count_clr clears out_err_count (wins over an increment)
//
// Parameters: DATA_W (normally `UNITWIDTH*`LANENUMBER), DEPTH (power of two,
// >= 4), ADDR_W = log2(DEPTH), STABLE_CYCLES (>= 2) ready-high cycles needed
// before the link is declared up.
//
// Build option: define PCSFEC_RXBUF_ERRDROP_EN to count errored words but
// never store them; out_error is then tied low. Without it, errored words
// are stored and delivered with out_error set.
// ---------------------------------------------------------------------------
module pcsfec_rx_frame_buffer #(
    parameter int DATA_W        = 256,
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int STABLE_CYCLES = 64
) (
    input  logic                               clkcore,
    input  logic                               reset_n_core,
    input  logic                               in_enable,
    pcsfec_rx_frame_buffer_if.slave            bus,
    output logic                               out_link_up,
    output logic [ADDR_W:0]                    out_fill_level,
    output logic                               out_overflow,
    input  logic                               in_overflow_clr,
    output logic [15:0]                        out_err_count,
    input  logic                               in_err_count_clr
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_DOWN  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_UP    = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   stable_cnt_q;
    logic               link_up_q;

    logic [ADDR_W:0]    wr_ptr_q;
    logic [ADDR_W:0]    rd_ptr_q;
    logic [DATA_W-1:0]  mem_data_q [DEPTH];
`ifndef PCSFEC_RXBUF_ERRDROP_EN
    logic [DEPTH-1:0]   mem_err_q;
`endif
    logic               overflow_q;
    logic [15:0]        err_count_q;

    logic               lane_ok_s;
    logic               empty_s;
    logic               full_s;
    logic               valid_s;
    logic               pop_s;
    logic               word_in_up_s;
    logic               storable_s;
    logic               push_s;
    logic               drop_s;
    logic               err_inc_s;

    // Link debounce state machine with the registered link-up output.
    always_ff @(posedge clkcore or negedge reset_n_core) begin
        if (!reset_n_core) begin
            state_q      <= ST_DOWN;
            stable_cnt_q <= '0;
            link_up_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_DOWN: begin
                    if (lane_ok_s) begin
                        // The first ready-high cycle already counts as one.
                        state_q      <= ST_WAIT;
                        stable_cnt_q <= CNT_W'(1);
                    end else begin
                        state_q      <= ST_DOWN;
                        stable_cnt_q <= '0;
                    end
                    link_up_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (!lane_ok_s) begin
                        state_q      <= ST_DOWN;
                        stable_cnt_q <= '0;
                        link_up_q    <= 1'b0;
                    end else if (stable_cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_q      <= ST_UP;
                        stable_cnt_q <= '0;
                        link_up_q    <= 1'b1;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + CNT_W'(1);
                        link_up_q    <= 1'b0;
                    end
                end
                ST_UP: begin
                    if (!lane_ok_s) begin
                        state_q   <= ST_FLUSH;
                        link_up_q <= 1'b0;
                    end else begin
                        link_up_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_q      <= ST_DOWN;
                    stable_cnt_q <= '0;
                    link_up_q    <= 1'b0;
                end
                default: begin
                    state_q      <= ST_DOWN;
                    stable_cnt_q <= '0;
                    link_up_q    <= 1'b0;
                end
            endcase
        end
    end

    // FIFO status and accept/drop decisions for the current cycle.
    always_comb begin
        lane_ok_s    = bus.phy_llp_ready & in_enable;
        empty_s      = (wr_ptr_q == rd_ptr_q);
        full_s       = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        // The head is hidden during FLUSH so nothing is popped while the
        // pointers are being discarded.
        valid_s      = !empty_s && (state_q != ST_FLUSH);
        pop_s        = valid_s & bus.in_ready;
        word_in_up_s = (state_q == ST_UP) & bus.phy_llp_data_valid;
`ifdef PCSFEC_RXBUF_ERRDROP_EN
        storable_s   = word_in_up_s & !bus.phy_llp_data_error;
`else
        storable_s   = word_in_up_s;
`endif
        // A pop in the same cycle frees the slot the push needs.
        push_s       = storable_s & (!full_s | pop_s);
        drop_s       = storable_s & full_s & !pop_s;
        err_inc_s    = word_in_up_s & bus.phy_llp_data_error &
                       (err_count_q != 16'hFFFF);
    end

    // FIFO pointers; FLUSH discards everything buffered.
    always_ff @(posedge clkcore or negedge reset_n_core) begin
        if (!reset_n_core) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (state_q == ST_FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + (ADDR_W + 1)'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + (ADDR_W + 1)'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
        end
    end

    // Word storage; cleared on reset so the head output reads zero.
    always_ff @(posedge clkcore or negedge reset_n_core) begin
        if (!reset_n_core) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
            end
`ifndef PCSFEC_RXBUF_ERRDROP_EN
            mem_err_q <= '0;
`endif
        end else if (push_s) begin
            mem_data_q[wr_ptr_q[ADDR_W-1:0]] <= bus.phy_llp_data;
`ifndef PCSFEC_RXBUF_ERRDROP_EN
            mem_err_q[wr_ptr_q[ADDR_W-1:0]]  <= bus.phy_llp_data_error;
`endif
        end
    end

    // Sticky overflow flag and saturating error counter.
    always_ff @(posedge clkcore or negedge reset_n_core) begin
        if (!reset_n_core) begin
            overflow_q  <= 1'b0;
            err_count_q <= 16'h0000;
        end else begin
            if (drop_s) begin
                overflow_q <= 1'b1;
            end else if (in_overflow_clr) begin
                overflow_q <= 1'b0;
            end else begin
                overflow_q <= overflow_q;
            end
            if (in_err_count_clr) begin
                err_count_q <= 16'h0000;
            end else if (err_inc_s) begin
                err_count_q <= err_count_q + 16'd1;
            end else begin
                err_count_q <= err_count_q;
            end
        end
    end

    assign bus.out_data   = mem_data_q[rd_ptr_q[ADDR_W-1:0]];
`ifdef PCSFEC_RXBUF_ERRDROP_EN
    assign bus.out_error  = 1'b0;
`else
    assign bus.out_error  = mem_err_q[rd_ptr_q[ADDR_W-1:0]];
`endif
    assign bus.out_valid  = valid_s;
    assign out_link_up    = link_up_q;
    assign out_fill_level = wr_ptr_q - rd_ptr_q;
    assign out_overflow   = overflow_q;
    assign out_err_count  = err_count_q;

endmodule
